// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared types and helpers for the ADC scan sequencer
package adc_seq_pkg;

    typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, CAPTURE} state_t;

    localparam int MAX_CH = 16;

    function automatic int ch_w(input int n);
        return n > 2 ? $clog2(n) : 1;
    endfunction

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [4:0] next_channel(input logic [MAX_CH-1:0] mask, input logic [4:0] from);
        next_channel = '0;
        for (int i = MAX_CH - 1; i >= 0; i--)
            if (mask[i] && 5'(i) >= from) next_channel = {1'b1, 4'(i)};
    endfunction

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// adc_scan_sequencer_if: result FIFO read port (valid/ready with channel tag and level)
interface adc_scan_sequencer_if #(
    parameter int CH_W     = 2,
    parameter int RESULT_W = 16,
    parameter int LVL_W    = 4
);
    logic                rd_valid;
    logic                rd_ready;
    logic [RESULT_W-1:0] rd_data;
    logic [CH_W-1:0]     rd_ch;
    logic [LVL_W-1:0]    fifo_level;

    modport master (output rd_valid, rd_data, rd_ch, fifo_level, input rd_ready);
    modport slave  (input rd_valid, rd_data, rd_ch, fifo_level, output rd_ready);
endinterface

// File: rtl/adc_seq_fifo.sv
// adc_seq_fifo: synchronous FIFO with occupancy level and drop-on-full
module adc_seq_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         valid,
    output logic [AW:0]  level,
    output logic         drop
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;

    assign do_pop  = pop && level != '0;
    assign do_push = push && (level != (AW+1)'(DEPTH) || do_pop);
    assign drop    = push && !do_push;
    assign valid   = level != '0;
    assign rdata   = mem[rp];

    // Storage and pointers; a pop in the same cycle frees the slot for a push on full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (do_push) mem[wp] <= wdata;
            wp    <= do_push ? wp + AW'(1) : wp;
            rp    <= do_pop ? rp + AW'(1) : rp;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: channel-mask scan, ADC start/capture, tagged result FIFO (optional watchdog: ADC_SEQ_TIMEOUT_EN)
module adc_scan_sequencer
    import adc_seq_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int RESULT_W    = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int SETTLE_CYC  = 4,
    parameter int START_CYC   = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  continuous,
    input  logic [N_CH-1:0]       ch_mask,
    output logic [ch_w(N_CH)-1:0] ch_sel_out,
    output logic                  start_conversion_out,
    input  logic                  conversion_finished_in,
    input  logic [RESULT_W-1:0]   result_in,
    adc_scan_sequencer_if.master  rd,
    output logic                  overflow,
    output logic                  busy
`ifdef ADC_SEQ_TIMEOUT_EN
    ,
    output logic                  timeout_flag
`endif
);
    localparam int CH_W    = ch_w(N_CH);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = TIMEOUT_CYC > START_CYC ? TIMEOUT_CYC : START_CYC;
    localparam int CNT_W   = $clog2((CNT_MAX > 255 ? CNT_MAX : 255) + 1);

    state_t                   state, state_n;
    logic [CH_W-1:0]          ch, ch_n;
    logic [N_CH-1:0]          scan_mask, scan_mask_n;
    logic [CNT_W-1:0]         cnt, cnt_n;
    logic [2:0]               fin_sync;
    logic                     fin_rise, start_q, enable_q, en_rise, push, drop, fifo_valid, tmo_hit;
    logic [RESULT_W-1:0]      result_q;
    logic [CH_W+RESULT_W-1:0] wdata, fifo_q;
    logic [AW:0]              fifo_level;
    logic [4:0]               nx, wr;

    assign fin_rise             = fin_sync[1] & ~fin_sync[2];
    assign en_rise              = enable & ~enable_q;
    assign nx                   = next_channel(MAX_CH'(scan_mask), 5'(ch) + 5'd1);
    assign wr                   = next_channel(MAX_CH'(ch_mask), 5'd0);
    assign ch_sel_out           = ch;
    assign start_conversion_out = start_q;
    assign busy                 = state != IDLE;

`ifdef ADC_SEQ_TIMEOUT_EN
    logic tmo_q;
    assign tmo_hit      = state == WAIT && !fin_rise && cnt == CNT_W'(TIMEOUT_CYC - 1);
    assign wdata        = {ch, tmo_q ? {RESULT_W{1'b1}} : result_q};
    // Remember that the pending capture came from the watchdog and flag it stickily.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q        <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            tmo_q        <= tmo_hit;
            timeout_flag <= en_rise ? 1'b0 : timeout_flag | tmo_hit;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign wdata   = {ch, result_q};
`endif

    // Next-state logic: scan the latched mask upward, wrapping only in continuous mode.
    always_comb begin
        state_n     = state;
        ch_n        = ch;
        scan_mask_n = scan_mask;
        cnt_n       = cnt + CNT_W'(1);
        push        = 1'b0;
        case (state)
            IDLE: if (enable && wr[4]) begin
                state_n     = SETTLE;
                scan_mask_n = ch_mask;
                ch_n        = CH_W'(wr[3:0]);
                cnt_n       = '0;
            end
            SETTLE: if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                state_n = START;
                cnt_n   = '0;
            end
            START: if (cnt == CNT_W'(START_CYC - 1)) begin
                state_n = WAIT;
                cnt_n   = '0;
            end
            WAIT: if (fin_rise || tmo_hit) state_n = CAPTURE;
            CAPTURE: begin
                push  = 1'b1;
                cnt_n = '0;
                if (!enable) state_n = IDLE;
                else if (nx[4]) begin
                    state_n = SETTLE;
                    ch_n    = CH_W'(nx[3:0]);
                end else if (continuous && wr[4]) begin
                    state_n     = SETTLE;
                    scan_mask_n = ch_mask;
                    ch_n        = CH_W'(wr[3:0]);
                end else state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM registers, registered start strobe and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ch        <= '0;
            scan_mask <= '0;
            cnt       <= '0;
            start_q   <= 1'b0;
            enable_q  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            ch        <= ch_n;
            scan_mask <= scan_mask_n;
            cnt       <= cnt_n;
            start_q   <= state == START;
            enable_q  <= enable;
            overflow  <= en_rise ? 1'b0 : overflow | drop;
        end
    end

    // Two-flop synchroniser plus edge flop; edge flop starts high so no edge fires out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fin_sync <= 3'b100;
            result_q <= '0;
        end else begin
            fin_sync <= {fin_sync[1:0], conversion_finished_in};
            result_q <= fin_rise ? result_in : result_q;
        end
    end

    adc_seq_fifo #(.W(CH_W + RESULT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (rd.rd_ready),
        .rdata (fifo_q),
        .valid (fifo_valid),
        .level (fifo_level),
        .drop  (drop)
    );

    assign rd.rd_valid          = fifo_valid;
    assign rd.fifo_level        = fifo_level;
    assign {rd.rd_ch, rd.rd_data} = fifo_q;
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: directed table-driven bench for the ADC scan sequencer
module tb_adc_scan_sequencer;
    logic        clk, rst, enable, continuous;
    logic [3:0]  ch_mask;
    logic [1:0]  ch_sel_out;
    logic        start_conversion_out, overflow, busy;
    logic        conversion_finished_in;
    logic [15:0] result_in;
    logic        adc_auto, auto_fin, man_fin;
    logic [15:0] auto_res, man_res;
    logic [15:0] adc_val [4];
    int          n_chk, n_fail;
`ifdef ADC_SEQ_TIMEOUT_EN
    logic        timeout_flag;
`endif

    typedef struct packed {
        logic [3:0]        mask;
        logic [3:0]        n;
        logic [3:0][1:0]   ch;
        logic [3:0][15:0]  d;
    } vec_t;
    vec_t vecs [7];

    adc_scan_sequencer_if #(.CH_W(2), .RESULT_W(16), .LVL_W(4)) rd_if ();

    adc_scan_sequencer dut (
`ifdef ADC_SEQ_TIMEOUT_EN
        .timeout_flag           (timeout_flag),
`endif
        .clk                    (clk),
        .rst                    (rst),
        .enable                 (enable),
        .continuous             (continuous),
        .ch_mask                (ch_mask),
        .ch_sel_out             (ch_sel_out),
        .start_conversion_out   (start_conversion_out),
        .conversion_finished_in (conversion_finished_in),
        .result_in              (result_in),
        .rd                     (rd_if),
        .overflow               (overflow),
        .busy                   (busy)
    );

    assign conversion_finished_in = adc_auto ? auto_fin : man_fin;
    assign result_in              = adc_auto ? auto_res : man_res;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ADC model: result for the selected channel, finished pulse asynchronous to clk.
    initial begin
        auto_fin = 1'b0;
        auto_res = '0;
        forever begin
            @(posedge start_conversion_out);
            if (adc_auto) begin
                #23 auto_res = adc_val[ch_sel_out];
                #4  auto_fin = 1'b1;
                #40 auto_fin = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic pop_check(input string name, input logic [1:0] ch, input logic [15:0] d);
        check({name, "_valid"}, 32'(rd_if.rd_valid), 32'd1);
        check({name, "_ch"}, 32'(rd_if.rd_ch), 32'(ch));
        check({name, "_data"}, 32'(rd_if.rd_data), 32'(d));
        rd_if.rd_ready = 1'b1;
        @(negedge clk);
        rd_if.rd_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int i = 0;
        while (busy && i < 400) begin
            @(negedge clk);
            i++;
        end
        if (busy) expire("wait_idle");
    endtask

    task automatic wait_level(input int n);
        int i = 0;
        while (int'(rd_if.fifo_level) < n && i < 400) begin
            @(negedge clk);
            i++;
        end
        if (int'(rd_if.fifo_level) < n) expire("wait_level");
    endtask

    task automatic wait_start_fall();
        int i = 0;
        while (!start_conversion_out && i < 100) begin
            @(negedge clk);
            i++;
        end
        while (start_conversion_out && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (i >= 100) expire("wait_start");
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        enable = 1'b0;
        continuous = 1'b0;
        ch_mask = '0;
        man_fin = 1'b0;
        man_res = '0;
        adc_auto = 1'b1;
        rd_if.rd_ready = 1'b0;
        adc_val[0] = 16'h0F00;
        adc_val[1] = 16'h0123;
        adc_val[2] = 16'h5A5A;
        adc_val[3] = 16'h0ABC;
        vecs[0] = '{4'b1010, 4'd2, {2'd0, 2'd0, 2'd3, 2'd1}, {16'h0, 16'h0, 16'h0ABC, 16'h0123}};
        vecs[1] = '{4'b0001, 4'd1, {2'd0, 2'd0, 2'd0, 2'd0}, {16'h0, 16'h0, 16'h0, 16'h0F00}};
        vecs[2] = '{4'b1111, 4'd4, {2'd3, 2'd2, 2'd1, 2'd0}, {16'h0ABC, 16'h5A5A, 16'h0123, 16'h0F00}};
        vecs[3] = '{4'b1000, 4'd1, {2'd0, 2'd0, 2'd0, 2'd3}, {16'h0, 16'h0, 16'h0, 16'h0ABC}};
        vecs[4] = '{4'b0110, 4'd2, {2'd0, 2'd0, 2'd2, 2'd1}, {16'h0, 16'h0, 16'h5A5A, 16'h0123}};
        vecs[5] = '{4'b0000, 4'd0, {2'd0, 2'd0, 2'd0, 2'd0}, {16'h0, 16'h0, 16'h0, 16'h0}};
        vecs[6] = '{4'b0101, 4'd2, {2'd0, 2'd0, 2'd2, 2'd0}, {16'h0, 16'h0, 16'h5A5A, 16'h0F00}};

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(start_conversion_out), 32'd0);
        check("rst_ch_sel", 32'(ch_sel_out), 32'd0);
        check("rst_rd_valid", 32'(rd_if.rd_valid), 32'd0);
        check("rst_level", 32'(rd_if.fifo_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        // Start strobe timing on the first scan: high at cycles 5 and 6 after leaving IDLE.
        @(negedge clk);
        ch_mask = 4'b1010;
        enable = 1'b1;
        @(negedge clk);
        check("first_busy", 32'(busy), 32'd1);
        check("first_ch_sel", 32'(ch_sel_out), 32'd1);
        for (int m = 0; m <= 7; m++) begin
            if (m > 0) @(negedge clk);
            check($sformatf("start_at_%0d", m), 32'(start_conversion_out), 32'(m == 5 || m == 6));
        end
        wait_idle();
        enable = 1'b0;
        check("first_idle", 32'(busy), 32'd0);
        pop_check("first_e0", 2'd1, 16'h0123);
        pop_check("first_e1", 2'd3, 16'h0ABC);
        check("first_empty", 32'(rd_if.rd_valid), 32'd0);

        // Single-pass scans from the vector table.
        for (int v = 0; v < 7; v++) begin
            ch_mask = vecs[v].mask;
            enable = 1'b1;
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].n != 0));
            wait_idle();
            enable = 1'b0;
            check($sformatf("vec%0d_level", v), 32'(rd_if.fifo_level), 32'(vecs[v].n));
            for (int j = 0; j < int'(vecs[v].n); j++)
                pop_check($sformatf("vec%0d_e%0d", v, j), vecs[v].ch[j], vecs[v].d[j]);
            @(negedge clk);
        end

        // Continuous single channel, mask changed mid-conversion takes effect at the wrap.
        ch_mask = 4'b0001;
        continuous = 1'b1;
        enable = 1'b1;
        wait_level(2);
        begin
            int i = 0;
            while (!start_conversion_out && i < 100) begin
                @(negedge clk);
                i++;
            end
            if (!start_conversion_out) expire("cont_start");
        end
        ch_mask = 4'b0110;
        wait_level(5);
        enable = 1'b0;
        continuous = 1'b0;
        wait_idle();
        check("cont_level", 32'(rd_if.fifo_level), 32'd6);
        pop_check("cont_e0", 2'd0, 16'h0F00);
        pop_check("cont_e1", 2'd0, 16'h0F00);
        pop_check("cont_e2", 2'd0, 16'h0F00);
        pop_check("cont_e3", 2'd1, 16'h0123);
        pop_check("cont_e4", 2'd2, 16'h5A5A);
        pop_check("cont_e5", 2'd1, 16'h0123);

        // Overflow: nine or more conversions with no reads; the extras are dropped.
        ch_mask = 4'b1111;
        continuous = 1'b1;
        enable = 1'b1;
        begin
            int i = 0;
            while (!overflow && i < 400) begin
                @(negedge clk);
                i++;
            end
            if (!overflow) expire("ovf_wait");
        end
        enable = 1'b0;
        continuous = 1'b0;
        wait_idle();
        check("ovf_level", 32'(rd_if.fifo_level), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head_ch", 32'(rd_if.rd_ch), 32'd0);
        check("ovf_head_data", 32'(rd_if.rd_data), 32'h0F00);

        // Push and pop in the same cycle on a full FIFO; rising enable clears overflow.
        adc_auto = 1'b0;
        ch_mask = 4'b0100;
        enable = 1'b1;
        wait_start_fall();
        man_res = 16'hBEEF;
        man_fin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rd_if.rd_ready = 1'b1;
        @(negedge clk);
        rd_if.rd_ready = 1'b0;
        man_fin = 1'b0;
        check("pp_level", 32'(rd_if.fifo_level), 32'd8);
        check("pp_overflow", 32'(overflow), 32'd0);
        wait_idle();
        enable = 1'b0;
        for (int j = 1; j < 8; j++)
            pop_check($sformatf("pp_e%0d", j), 2'(j % 4), adc_val[j % 4]);
        pop_check("pp_new", 2'd2, 16'hBEEF);
        check("pp_empty", 32'(rd_if.rd_valid), 32'd0);

        // Finished held high into WAIT must not capture; one async 3-cycle pulse captures once.
        ch_mask = 4'b0100;
        enable = 1'b1;
        @(negedge clk);
        man_res = 16'h1111;
        man_fin = 1'b1;
        wait_start_fall();
        repeat (10) @(negedge clk);
        check("glitch_held_level", 32'(rd_if.fifo_level), 32'd0);
        check("glitch_held_busy", 32'(busy), 32'd1);
        man_fin = 1'b0;
        repeat (4) @(negedge clk);
        #3 man_res = 16'h2468;
        man_fin = 1'b1;
        #30 man_fin = 1'b0;
        @(negedge clk);
        wait_idle();
        enable = 1'b0;
        check("glitch_level", 32'(rd_if.fifo_level), 32'd1);
        check("glitch_ch", 32'(rd_if.rd_ch), 32'd2);
        check("glitch_data", 32'(rd_if.rd_data), 32'h2468);

        // Reset while waiting on the ADC, then restart from the lowest mask bit.
        @(negedge clk);
        ch_mask = 4'b1010;
        enable = 1'b1;
        wait_start_fall();
        #2 rst = 1'b1;
        #1;
        check("wrst_busy", 32'(busy), 32'd0);
        check("wrst_start", 32'(start_conversion_out), 32'd0);
        check("wrst_ch_sel", 32'(ch_sel_out), 32'd0);
        check("wrst_rd_valid", 32'(rd_if.rd_valid), 32'd0);
        check("wrst_level", 32'(rd_if.fifo_level), 32'd0);
        check("wrst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        adc_auto = 1'b1;
        @(negedge clk);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_ch_sel", 32'(ch_sel_out), 32'd1);
        wait_idle();
        enable = 1'b0;
        check("restart_level", 32'(rd_if.fifo_level), 32'd2);
        pop_check("restart_e0", 2'd1, 16'h0123);
        pop_check("restart_e1", 2'd3, 16'h0ABC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
